// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_unit
//  Purpose  : EX-stage operand forwarding (MEM over WB) and load-use stall
//             control with a saturating stall-cycle statistics counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int CPU_WIDTH         = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int NUM_SRC           = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]                id_rs_used,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ex_rs_addr,
    input  logic [NUM_SRC*CPU_WIDTH-1:0]      ex_rs_data,
    input  logic [REG_ADDR_WIDTH-1:0]         ex_rd_addr,
    input  logic                              ex_rd_wen,
    input  logic                              ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0]         m_rd_addr,
    input  logic                              m_rd_wen,
    input  logic [CPU_WIDTH-1:0]              m_rd_data,
    input  logic [REG_ADDR_WIDTH-1:0]         wb_rd_addr,
    input  logic                              wb_rd_wen,
    input  logic [CPU_WIDTH-1:0]              wb_rd_data,
    input  logic                              stat_clr,
    output logic [NUM_SRC*2-1:0]              fwd_sel,
    output logic [NUM_SRC*CPU_WIDTH-1:0]      fwd_data,
    output logic                              stall_if_id,
    output logic                              bubble_ex,
    output logic [CNT_WIDTH-1:0]              stall_count
);

    localparam int                   RAW      = REG_ADDR_WIDTH;
    localparam logic [1:0]           SEL_RF   = 2'b00;
    localparam logic [1:0]           SEL_MEM  = 2'b10;
    localparam logic [1:0]           SEL_WB   = 2'b01;
    localparam logic [1:0]           CNT_LOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;
    logic                   w_load_use;
    logic                   w_stall;

    // Forwarding select and operand mux per source; MEM is the younger result so it wins over WB.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_rd_wen && (m_rd_addr != '0) && (m_rd_addr == ex_rs_addr[i*RAW +: RAW])) begin
                fwd_sel[i*2 +: 2] = SEL_MEM;
            end else if (wb_rd_wen && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs_addr[i*RAW +: RAW])) begin
                fwd_sel[i*2 +: 2] = SEL_WB;
            end else begin
                fwd_sel[i*2 +: 2] = SEL_RF;
            end
            case (fwd_sel[i*2 +: 2])
                SEL_MEM: fwd_data[i*CPU_WIDTH +: CPU_WIDTH] = m_rd_data;
                SEL_WB:  fwd_data[i*CPU_WIDTH +: CPU_WIDTH] = wb_rd_data;
                default: fwd_data[i*CPU_WIDTH +: CPU_WIDTH] = ex_rs_data[i*CPU_WIDTH +: CPU_WIDTH];
            endcase
        end
    end

    // Load-use detection: a load in EX whose destination is read by the instruction in ID.
    always_comb begin
        w_load_use = 1'b0;
        if (ex_is_load && ex_rd_wen && (ex_rd_addr != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_rs_used[i] && (id_rs_addr[i*RAW +: RAW] == ex_rd_addr)) begin
                    w_load_use = 1'b1;
                end
            end
        end
    end

    // Stall FSM next-state: Mealy stall on the hazard cycle, then count out the remaining cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load_use) begin
                    w_stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            STALL: begin
                w_stall = 1'b1;
                cnt_d   = cnt_q - 2'd1;
                // <= 1 also recovers from an unreachable zero count instead of wrapping
                if (cnt_q <= 2'd1) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Stall outputs are forced low while reset is held, even if a hazard is visible.
    assign stall_if_id = rst_n & w_stall;
    assign bubble_ex   = rst_n & w_stall;

    // Statistics counter next value: clear wins over increment, increment saturates.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = '0;
        end else if (stall_if_id && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State, down-counter and statistics registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_fwd_unit
//  Purpose  : Directed self-checking bench for hazard_fwd_unit; three
//             instances share stimulus (LOAD_STALL_CYCLES=1, =3, CNT_WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    localparam int CW  = 32;
    localparam int RAW = 5;
    localparam int NS  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NS*RAW-1:0] id_rs_addr;
    logic [NS-1:0]     id_rs_used;
    logic [NS*RAW-1:0] ex_rs_addr;
    logic [NS*CW-1:0]  ex_rs_data;
    logic [RAW-1:0]    ex_rd_addr;
    logic              ex_rd_wen;
    logic              ex_is_load;
    logic [RAW-1:0]    m_rd_addr;
    logic              m_rd_wen;
    logic [CW-1:0]     m_rd_data;
    logic [RAW-1:0]    wb_rd_addr;
    logic              wb_rd_wen;
    logic [CW-1:0]     wb_rd_data;
    logic              stat_clr;

    logic [NS*2-1:0]   sel1, sel3, sel4;
    logic [NS*CW-1:0]  dat1, dat3, dat4;
    logic              s1, s3, s4, b1, b3, b4;
    logic [15:0]       cnt1, cnt3;
    logic [3:0]        cnt4;

    int n_cmp = 0;
    int n_err = 0;

    hazard_fwd_unit #(.LOAD_STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
        .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load), .m_rd_addr(m_rd_addr),
        .m_rd_wen(m_rd_wen), .m_rd_data(m_rd_data), .wb_rd_addr(wb_rd_addr),
        .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data), .stat_clr(stat_clr),
        .fwd_sel(sel1), .fwd_data(dat1), .stall_if_id(s1), .bubble_ex(b1), .stall_count(cnt1)
    );

    hazard_fwd_unit #(.LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
        .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load), .m_rd_addr(m_rd_addr),
        .m_rd_wen(m_rd_wen), .m_rd_data(m_rd_data), .wb_rd_addr(wb_rd_addr),
        .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data), .stat_clr(stat_clr),
        .fwd_sel(sel3), .fwd_data(dat3), .stall_if_id(s3), .bubble_ex(b3), .stall_count(cnt3)
    );

    hazard_fwd_unit #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
        .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load), .m_rd_addr(m_rd_addr),
        .m_rd_wen(m_rd_wen), .m_rd_data(m_rd_data), .wb_rd_addr(wb_rd_addr),
        .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data), .stat_clr(stat_clr),
        .fwd_sel(sel4), .fwd_data(dat4), .stall_if_id(s4), .bubble_ex(b4), .stall_count(cnt4)
    );

    // Quiet pipeline: nothing writes, nothing loads.
    task automatic drive_idle();
        id_rs_addr = '0; id_rs_used = '0; ex_rs_addr = '0; ex_rs_data = '0;
        ex_rd_addr = '0; ex_rd_wen = 1'b0; ex_is_load = 1'b0;
        m_rd_addr = '0; m_rd_wen = 1'b0; m_rd_data = '0;
        wb_rd_addr = '0; wb_rd_wen = 1'b0; wb_rd_data = '0;
        stat_clr = 1'b0;
    endtask

    // lw x7 in EX, add reading x7 (source 0) in ID.
    task automatic set_load_use(input logic on);
        ex_is_load = on; ex_rd_wen = on; ex_rd_addr = 5'd7;
        id_rs_addr = {5'd3, 5'd7};
        id_rs_used = on ? 2'b01 : 2'b00;
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        set_load_use(1'b1);
        m_rd_addr = 5'd5; m_rd_wen = 1'b1; m_rd_data = 32'h1234_5678; ex_rs_addr = {5'd0, 5'd5};
        #2;
        n_cmp++; if (s1 !== 1'b0) begin n_err++; $display("FAIL rst_stall1: got %b want 0", s1); end
        n_cmp++; if (b3 !== 1'b0) begin n_err++; $display("FAIL rst_bubble3: got %b want 0", b3); end
        n_cmp++; if (cnt1 !== 16'h0) begin n_err++; $display("FAIL rst_cnt1: got %h want 0", cnt1); end
        n_cmp++; if (cnt4 !== 4'h0) begin n_err++; $display("FAIL rst_cnt4: got %h want 0", cnt4); end
        n_cmp++; if (sel1[1:0] !== 2'b10) begin n_err++; $display("FAIL rst_fwd_sel: got %b want 10", sel1[1:0]); end
        n_cmp++; if (dat1[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL rst_fwd_data: got %h want 12345678", dat1[31:0]); end
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (s1 !== 1'b0) begin n_err++; $display("FAIL post_rst_stall1: got %b want 0", s1); end
        @(posedge clk); #1;
    endtask

    task automatic test_fwd_priority();
        ex_rs_addr = {5'd9, 5'd5};
        ex_rs_data = {32'h2222_2222, 32'h1111_1111};
        m_rd_addr = 5'd5;  m_rd_wen = 1'b1;  m_rd_data = 32'hAAAA_0000;
        wb_rd_addr = 5'd5; wb_rd_wen = 1'b1; wb_rd_data = 32'h0000_5555;
        #1;
        n_cmp++; if (sel1[1:0] !== 2'b10) begin n_err++; $display("FAIL prio_sel0: got %b want 10", sel1[1:0]); end
        n_cmp++; if (dat1[31:0] !== 32'hAAAA_0000) begin n_err++; $display("FAIL prio_data0: got %h want aaaa0000", dat1[31:0]); end
        n_cmp++; if (sel1[3:2] !== 2'b00) begin n_err++; $display("FAIL prio_sel1: got %b want 00", sel1[3:2]); end
        n_cmp++; if (dat1[63:32] !== 32'h2222_2222) begin n_err++; $display("FAIL prio_data1: got %h want 22222222", dat1[63:32]); end
        m_rd_wen = 1'b0;
        #1;
        n_cmp++; if (sel1[1:0] !== 2'b01) begin n_err++; $display("FAIL wb_sel0: got %b want 01", sel1[1:0]); end
        n_cmp++; if (dat1[31:0] !== 32'h0000_5555) begin n_err++; $display("FAIL wb_data0: got %h want 00005555", dat1[31:0]); end
        wb_rd_wen = 1'b0;
        #1;
        n_cmp++; if (sel1[1:0] !== 2'b00) begin n_err++; $display("FAIL rf_sel0: got %b want 00", sel1[1:0]); end
        n_cmp++; if (dat1[31:0] !== 32'h1111_1111) begin n_err++; $display("FAIL rf_data0: got %h want 11111111", dat1[31:0]); end
        m_rd_wen = 1'b1; wb_rd_addr = 5'd9; wb_rd_wen = 1'b1;
        #1;
        n_cmp++; if (sel1 !== 4'b0110) begin n_err++; $display("FAIL split_sel: got %b want 0110", sel1); end
        n_cmp++; if (dat1 !== {32'h0000_5555, 32'hAAAA_0000}) begin n_err++; $display("FAIL split_data: got %h want 00005555aaaa0000", dat1); end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_x0();
        ex_rs_addr = {5'd0, 5'd5};
        ex_rs_data = {32'h3333_3333, 32'h4444_4444};
        m_rd_addr = 5'd0;  m_rd_wen = 1'b1;  m_rd_data = 32'hDEAD_DEAD;
        wb_rd_addr = 5'd0; wb_rd_wen = 1'b1; wb_rd_data = 32'hBEEF_BEEF;
        ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd_addr = 5'd0;
        id_rs_addr = {5'd4, 5'd0}; id_rs_used = 2'b11;
        @(negedge clk);
        n_cmp++; if (sel1 !== 4'b0000) begin n_err++; $display("FAIL x0_sel: got %b want 0000", sel1); end
        n_cmp++; if (dat1[63:32] !== 32'h3333_3333) begin n_err++; $display("FAIL x0_data1: got %h want 33333333", dat1[63:32]); end
        n_cmp++; if (s1 !== 1'b0) begin n_err++; $display("FAIL x0_no_stall: got %b want 0", s1); end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_stall_lsc1();
        clear_stats();
        set_load_use(1'b1);
        @(negedge clk);
        n_cmp++; if (s1 !== 1'b1) begin n_err++; $display("FAIL lsc1_stall_c0: got %b want 1", s1); end
        n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL lsc1_bubble_c0: got %b want 1", b1); end
        @(posedge clk); #1;
        set_load_use(1'b0);
        @(negedge clk);
        n_cmp++; if (s1 !== 1'b0) begin n_err++; $display("FAIL lsc1_stall_c1: got %b want 0", s1); end
        n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL lsc1_bubble_c1: got %b want 0", b1); end
        @(posedge clk); #1;
        n_cmp++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL lsc1_count: got %0d want 1", cnt1); end
        settle();
    endtask

    task automatic test_stall_lsc3();
        logic [4:0] exp_seq;
        exp_seq = 5'b00111;
        clear_stats();
        set_load_use(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (s3 !== exp_seq[k]) begin n_err++; $display("FAIL lsc3_stall_c%0d: got %b want %b", k, s3, exp_seq[k]); end
            if (k == 1) begin
                m_rd_addr = 5'd3; m_rd_wen = 1'b1; m_rd_data = 32'hCAFE_0001; ex_rs_addr = {5'd3, 5'd0};
                #1;
                n_cmp++; if (sel3[3:2] !== 2'b10) begin n_err++; $display("FAIL lsc3_fwd_in_stall: got %b want 10", sel3[3:2]); end
                n_cmp++; if (b3 !== 1'b1) begin n_err++; $display("FAIL lsc3_bubble_c1: got %b want 1", b3); end
            end
            @(posedge clk); #1;
            if (k == 0) set_load_use(1'b0);
        end
        n_cmp++; if (cnt3 !== 16'd3) begin n_err++; $display("FAIL lsc3_count: got %0d want 3", cnt3); end
        drive_idle();
        settle();
    endtask

    task automatic test_back_to_back();
        clear_stats();
        set_load_use(1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_cmp++; if (s3 !== (k <= 5)) begin n_err++; $display("FAIL b2b_lsc3_c%0d: got %b want %b", k, s3, (k <= 5)); end
            n_cmp++; if (s1 !== (k <= 3)) begin n_err++; $display("FAIL b2b_lsc1_c%0d: got %b want %b", k, s1, (k <= 3)); end
            @(posedge clk); #1;
            if (k == 3) set_load_use(1'b0);
        end
        n_cmp++; if (cnt3 !== 16'd6) begin n_err++; $display("FAIL b2b_count3: got %0d want 6", cnt3); end
        n_cmp++; if (cnt1 !== 16'd4) begin n_err++; $display("FAIL b2b_count1: got %0d want 4", cnt1); end
        settle();
    endtask

    task automatic test_reset_mid_stall();
        clear_stats();
        set_load_use(1'b1);
        @(posedge clk); #1;
        set_load_use(1'b0);
        @(negedge clk);
        n_cmp++; if (s3 !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %b want 1", s3); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (s3 !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall: got %b want 0", s3); end
        n_cmp++; if (b3 !== 1'b0) begin n_err++; $display("FAIL mid_rst_bubble: got %b want 0", b3); end
        n_cmp++; if (cnt3 !== 16'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", cnt3); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (s3 !== 1'b0) begin n_err++; $display("FAIL mid_residual_c%0d: got %b want 0", k, s3); end
        end
        n_cmp++; if (cnt3 !== 16'd0) begin n_err++; $display("FAIL mid_post_count: got %0d want 0", cnt3); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        clear_stats();
        set_load_use(1'b1);
        repeat (14) @(posedge clk);
        #1;
        n_cmp++; if (cnt4 !== 4'hE) begin n_err++; $display("FAIL sat_count14: got %h want e", cnt4); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (cnt4 !== 4'hF) begin n_err++; $display("FAIL sat_count20: got %h want f", cnt4); end
        stat_clr = 1'b1;
        @(negedge clk);
        n_cmp++; if (s4 !== 1'b1) begin n_err++; $display("FAIL sat_clr_stall: got %b want 1", s4); end
        @(posedge clk); #1;
        stat_clr = 1'b0;
        n_cmp++; if (cnt4 !== 4'h0) begin n_err++; $display("FAIL sat_clr_wins: got %h want 0", cnt4); end
        @(posedge clk); #1;
        n_cmp++; if (cnt4 !== 4'h1) begin n_err++; $display("FAIL sat_after_clr: got %h want 1", cnt4); end
        drive_idle();
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fwd_priority();
        test_x0();
        test_stall_lsc1();
        test_stall_lsc3();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL take these parameters: CPU_WIDTH, default 32, operand width; REG_ADDR_WIDTH, default 5, register address width; NUM_SRC, default 2, source operands per instruction; LOAD_STALL_CYCLES, default 1, legal range 1..3, stall cycles per load-use hazard; CNT_WIDTH, default 16, stall statistics counter width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- id_rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  ID-stage source addresses; source i is at slice [i*RAW +: RAW].
- id_rs_used  in  NUM_SRC  ID source i is read.
- ex_rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  EX-stage source addresses.
- ex_rs_data  in  NUM_SRC*CPU_WIDTH  EX-stage register-file operands.
- ex_rd_addr, ex_rd_wen, ex_is_load  in  RAW/1/1  EX destination, write enable, load flag.
- m_rd_addr, m_rd_wen  in  RAW/1  MEM destination and write enable.
- m_rd_data  in  CPU_WIDTH  MEM result; load data is valid in MEM.
- wb_rd_addr, wb_rd_wen  in  RAW/1  WB destination and write enable.
- wb_rd_data  in  CPU_WIDTH  WB result.
- stat_clr  in  1  synchronous clear of stall_count.
- fwd_sel  out  NUM_SRC*2  per-source select: 00 = register file, 10 = MEM, 01 = WB.
- fwd_data  out  NUM_SRC*CPU_WIDTH  forwarded EX operands.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert a NOP into ID/EX.
- stall_count  out  CNT_WIDTH  saturating count of stall cycles.

Function
REQ-004 For each source i, fwd_sel SHALL be 10 when m_rd_wen=1, m_rd_addr!=0 and m_rd_addr equals ex_rs_addr[i].
REQ-005 Otherwise, fwd_sel SHALL be 01 when wb_rd_wen=1, wb_rd_addr!=0 and wb_rd_addr equals ex_rs_addr[i].
REQ-006 In all other cases, fwd_sel SHALL be 00, so MEM has priority over WB.
REQ-007 fwd_data[i] SHALL equal m_rd_data, wb_rd_data or ex_rs_data[i] according to fwd_sel[i]; code 11 is never produced, and its decode SHALL return ex_rs_data[i]; the logic SHALL be combinational, latch-free and zero-latency.
REQ-008 Register x0 SHALL never be forwarded or trigger a hazard.
REQ-009 A hazard SHALL exist when ex_is_load=1, ex_rd_wen=1, ex_rd_addr!=0, and ex_rd_addr equals id_rs_addr[i] for some i with id_rs_used[i]=1.
REQ-010 The stall FSM SHALL have two states, IDLE and STALL, plus a 2-bit down-counter cnt.
REQ-011 In IDLE with a hazard, stall_if_id and bubble_ex SHALL be 1 in that same cycle (Mealy).
REQ-012 On that hazard, if LOAD_STALL_CYCLES=1 the FSM SHALL stay in IDLE; otherwise it SHALL go to STALL with cnt=LOAD_STALL_CYCLES-1.
REQ-013 In STALL, stall_if_id and bubble_ex SHALL be 1 and cnt SHALL decrement each cycle; when cnt=1 the FSM SHALL return to IDLE on the next edge.
REQ-014 Hazard detection SHALL be ignored while in STALL and re-evaluated in the first IDLE cycle.
REQ-015 Back-to-back load-use pairs SHALL each produce a full LOAD_STALL_CYCLES stall.
REQ-016 Forwarding SHALL remain active during stalls.
REQ-017 stall_count SHALL increment on every clock edge where stall_if_id=1 and saturate at all-ones.
REQ-018 When stat_clr=1, stall_count SHALL become 0 on the next edge; if stat_clr=1 coincides with a stall cycle, the clear SHALL win.

Reset
REQ-019 When rst_n=0, the FSM SHALL go to IDLE, cnt to 0 and stall_count to 0 immediately, without waiting for clk.
REQ-020 During reset, stall_if_id and bubble_ex SHALL be 0.
REQ-021 A reset asserted in the middle of a stall SHALL abort the stall, and the first edge after release SHALL start in IDLE.
REQ-022 fwd_sel and fwd_data SHALL remain purely combinational during reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- MEM and WB both write x5, ex_rs_addr[0]=5, m_rd_data=0xAAAA0000, wb_rd_data=0x5555 -> fwd_sel[0]=10, fwd_data[0]=0xAAAA0000.
- m_rd_addr=0 with wen=1, ex_rs_addr[1]=0 -> fwd_sel[1]=00, fwd_data[1]=ex_rs_data[1].
- LOAD_STALL_CYCLES=1, EX lw x7, ID add reading x7 -> exactly 1 cycle of stall_if_id=bubble_ex=1, then 0; stall_count=1.
- LOAD_STALL_CYCLES=3, same hazard -> 3 consecutive stall cycles, then IDLE; stall_count=3.
- rst_n dropped in the 2nd stall cycle (LOAD_STALL_CYCLES=3) -> stall outputs 0 immediately, stall_count=0, no residual stall after release.
- CNT_WIDTH=4 with 20 stall cycles -> stall_count holds 0xF; stat_clr=1 during a stall -> 0 next edge.
